// File: rtl/fb_write_sequencer_if.sv
// Framebuffer write sequencer bus: UART/frame/clear requests in, RAM write port and status out.
interface fb_write_sequencer_if #(
    parameter int FB_ADDR_WIDTH = 13
);
    logic [7:0]               rx_data;
    logic                     rx_strobe;
    logic                     frame_start;
    logic                     clear_req;
    logic [7:0]               clear_value;
    logic                     wr_enable;
    logic [FB_ADDR_WIDTH-1:0] wr_addr;
    logic [7:0]               wr_data;
    logic [7:0]               tx_data;
    logic                     tx_strobe;
    logic                     busy;
    logic                     clear_done;

    modport master (
        output rx_data, rx_strobe, frame_start, clear_req, clear_value,
        input  wr_enable, wr_addr, wr_data, tx_data, tx_strobe, busy, clear_done
    );

    modport slave (
        input  rx_data, rx_strobe, frame_start, clear_req, clear_value,
        output wr_enable, wr_addr, wr_data, tx_data, tx_strobe, busy, clear_done
    );
endinterface

// File: rtl/fb_write_sequencer.sv
// Arbitrates the frame RAM write port between the UART pixel stream (strict priority) and a fill engine.
// Optional byte echo to uart_tx is built when FB_ECHO_EN is defined.
module fb_write_sequencer #(
    parameter int FB_ADDR_WIDTH = 13,
    parameter int FB_SIZE       = 6144,
    parameter int COLS          = 128,
    parameter int ROWS          = 32
) (
    input logic                 wr_clk,
    input logic                 reset,
    fb_write_sequencer_if.slave bus
);
    localparam int AW = FB_ADDR_WIDTH;
    localparam int PW = FB_ADDR_WIDTH + 1;
    localparam int XW = $clog2(COLS);
    localparam int YW = $clog2(ROWS);

    typedef enum logic {IDLE, FILL} state_t;

    state_t          state, state_n;
    logic [PW-1:0]   ptr, ptr_n, fill_ptr;
    logic [7:0]      fill_val, fill_val_n, fill_data;
    logic            fill_we, done_n;
    logic [XW-1:0]   x, x_n, cx;
    logic [YW-1:0]   y, y_n, cy;
    logic [AW-1:0]   base, uart_addr;
    logic            wr_enable, busy, clear_done;
    logic [AW-1:0]   wr_addr;
    logic [7:0]      wr_data;

    // frame_start takes effect before a same-cycle byte, so that byte lands on (0,0)
    always_comb begin
        cx  = bus.frame_start ? '0 : x;
        cy  = bus.frame_start ? '0 : y;
        x_n = cx;
        y_n = cy;
        if (bus.rx_strobe) begin
            if (cy == YW'(ROWS - 1)) begin
                y_n = '0;
                x_n = (cx == XW'(COLS - 1)) ? '0 : cx + 1'b1;
            end else begin
                y_n = cy + 1'b1;
            end
        end
        // Panel scramble: 16 column groups of 384 bytes, 8 sub-blocks of 48; stream skips rows 0..15
        base      = AW'(cx[3:0]) * AW'(384) + AW'(cx[6:4]) * AW'(48);
        uart_addr = cy[4] ? base + AW'(cy) : base + AW'(cy) + AW'(32);
    end

    always_comb begin
        state_n    = state;
        ptr_n      = ptr;
        fill_val_n = fill_val;
        fill_ptr   = ptr;
        fill_data  = fill_val;
        done_n     = 1'b0;
        if (bus.clear_req) begin
            state_n    = FILL;
            fill_val_n = bus.clear_value;
            ptr_n      = '0;
            fill_ptr   = '0;
            fill_data  = bus.clear_value;
        end else if (state == FILL && ptr == PW'(FB_SIZE)) begin
            state_n = IDLE;
            done_n  = 1'b1;
        end
        // A colliding UART byte steals the slot; the pointer simply holds
        fill_we = (state_n == FILL) && !bus.rx_strobe;
        if (fill_we) ptr_n = fill_ptr + 1'b1;
    end

    always_ff @(posedge wr_clk) begin
        if (reset) begin
            state      <= IDLE;
            ptr        <= '0;
            fill_val   <= '0;
            x          <= '0;
            y          <= '0;
            wr_enable  <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            busy       <= 1'b0;
            clear_done <= 1'b0;
        end else begin
            state      <= state_n;
            ptr        <= ptr_n;
            fill_val   <= fill_val_n;
            x          <= x_n;
            y          <= y_n;
            wr_enable  <= bus.rx_strobe | fill_we;
            wr_addr    <= bus.rx_strobe ? uart_addr : fill_ptr[AW-1:0];
            wr_data    <= bus.rx_strobe ? bus.rx_data : fill_data;
            busy       <= (state_n == FILL);
            clear_done <= done_n;
        end
    end

    assign bus.wr_enable  = wr_enable;
    assign bus.wr_addr    = wr_addr;
    assign bus.wr_data    = wr_data;
    assign bus.busy       = busy;
    assign bus.clear_done = clear_done;

`ifdef FB_ECHO_EN
    logic [7:0] tx_data;
    logic       tx_strobe;

    always_ff @(posedge wr_clk) begin
        if (reset) begin
            tx_data   <= '0;
            tx_strobe <= 1'b0;
        end else begin
            tx_strobe <= bus.rx_strobe;
            if (bus.rx_strobe) tx_data <= bus.rx_data;
        end
    end

    assign bus.tx_data   = tx_data;
    assign bus.tx_strobe = tx_strobe;
`else
    assign bus.tx_data   = '0;
    assign bus.tx_strobe = 1'b0;
`endif
endmodule

// File: tb/tb_fb_write_sequencer.sv
// Directed bench for fb_write_sequencer: stream mapping, wrap, frame sync, fill, collision, restart, reset, echo.
module tb_fb_write_sequencer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_chk = 0;
    int   n_pass = 0;

    fb_write_sequencer_if #(.FB_ADDR_WIDTH(13)) bus ();

    fb_write_sequencer #(
        .FB_ADDR_WIDTH(13), .FB_SIZE(6144), .COLS(128), .ROWS(32)
    ) dut (
        .wr_clk(clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.rx_strobe = 1'b0; bus.frame_start = 1'b0; bus.clear_req = 1'b0;
        bus.rx_data = '0; bus.clear_value = '0;
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
    endtask

    function automatic int exp_addr(int x, int y);
        return (x % 16) * 384 + (x / 16) * 48 + ((y < 16) ? 32 + y : y);
    endfunction

    task automatic test_reset();
        bus.rx_strobe = 1'b1; bus.rx_data = 8'hFF; bus.clear_req = 1'b1; bus.clear_value = 8'hFF;
        reset = 1'b1;
        tick();
        n_chk++;
        if ({bus.wr_enable, bus.wr_addr, bus.wr_data, bus.busy, bus.clear_done, bus.tx_strobe, bus.tx_data} !== '0)
            $display("FAIL reset_outputs: we=%b addr=%0d data=%h busy=%b done=%b txs=%b txd=%h",
                     bus.wr_enable, bus.wr_addr, bus.wr_data, bus.busy, bus.clear_done, bus.tx_strobe, bus.tx_data);
        else n_pass++;
        do_reset();
    endtask

    task automatic test_stream_map();
        int want [int];
        want[0] = 32; want[15] = 47; want[16] = 16; want[31] = 31; want[32] = 416;
        do_reset();
        for (int i = 0; i < 33; i++) begin
            bus.rx_strobe = 1'b1; bus.rx_data = 8'(i);
            tick();
            if (want.exists(i)) begin
                n_chk++;
                if (bus.wr_enable !== 1'b1 || bus.wr_addr !== 13'(want[i]) || bus.wr_data !== 8'(i))
                    $display("FAIL map_byte_%0h: we=%b addr=%0d data=%h want addr=%0d data=%h",
                             i, bus.wr_enable, bus.wr_addr, bus.wr_data, want[i], i);
                else n_pass++;
            end
        end
        bus.rx_strobe = 1'b0;
        tick();
        n_chk++;
        if (bus.wr_enable !== 1'b0) $display("FAIL map_idle_we: got %b want 0", bus.wr_enable);
        else n_pass++;
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 4097; i++) begin
            int x, y, e;
            x = (i / 32) % 128; y = i % 32;
            e = exp_addr(x, y);
            if (i == 512)  e = 80;
            if (i == 4095) e = 6127;
            if (i == 4096) e = 32;
            bus.rx_strobe = 1'b1; bus.rx_data = 8'(i * 7);
            tick();
            n_chk++;
            if (bus.wr_enable !== 1'b1 || bus.wr_addr !== 13'(e) || bus.wr_data !== 8'(i * 7))
                $display("FAIL wrap_byte_%0d: we=%b addr=%0d data=%h want addr=%0d data=%h",
                         i, bus.wr_enable, bus.wr_addr, bus.wr_data, e, 8'(i * 7));
            else n_pass++;
        end
        bus.rx_strobe = 1'b0;
        tick();
        n_chk++;
        if (bus.wr_enable !== 1'b0) $display("FAIL wrap_extra_we: got %b want 0", bus.wr_enable);
        else n_pass++;
    endtask

    task automatic test_frame_sync();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            bus.rx_strobe = 1'b1; bus.rx_data = 8'(i);
            tick();
        end
        bus.frame_start = 1'b1; bus.rx_data = 8'hAA;
        tick();
        bus.frame_start = 1'b0;
        n_chk++;
        if (bus.wr_enable !== 1'b1 || bus.wr_addr !== 13'd32 || bus.wr_data !== 8'hAA)
            $display("FAIL sync_aa: we=%b addr=%0d data=%h want addr=32 data=aa", bus.wr_enable, bus.wr_addr, bus.wr_data);
        else n_pass++;
        bus.rx_data = 8'hBB;
        tick();
        bus.rx_strobe = 1'b0;
        n_chk++;
        if (bus.wr_enable !== 1'b1 || bus.wr_addr !== 13'd33 || bus.wr_data !== 8'hBB)
            $display("FAIL sync_bb: we=%b addr=%0d data=%h want addr=33 data=bb", bus.wr_enable, bus.wr_addr, bus.wr_data);
        else n_pass++;
    endtask

    task automatic test_fill();
        int wr_cnt = 0, busy_cnt = 0, done_cnt = 0, done_k = -1, bad = 0;
        do_reset();
        bus.clear_value = 8'h3C; bus.clear_req = 1'b1;
        tick();
        bus.clear_req = 1'b0; bus.clear_value = 8'h00;
        n_chk++;
        if (bus.busy !== 1'b1 || bus.wr_enable !== 1'b1 || bus.wr_addr !== 13'd0)
            $display("FAIL fill_first: busy=%b we=%b addr=%0d want 1 1 0", bus.busy, bus.wr_enable, bus.wr_addr);
        else n_pass++;
        for (int k = 1; k <= 6150; k++) begin
            if (bus.wr_enable === 1'b1) begin
                if (bus.wr_addr !== 13'(wr_cnt) || bus.wr_data !== 8'h3C || k != wr_cnt + 1) bad++;
                wr_cnt++;
            end
            if (bus.busy === 1'b1) busy_cnt++;
            if (bus.clear_done === 1'b1) begin done_cnt++; done_k = k; end
            tick();
        end
        n_chk++;
        if (wr_cnt != 6144 || bad != 0) $display("FAIL fill_writes: count=%0d bad=%0d want 6144 0", wr_cnt, bad);
        else n_pass++;
        n_chk++;
        if (busy_cnt != 6144) $display("FAIL fill_busy_cycles: got %0d want 6144", busy_cnt);
        else n_pass++;
        n_chk++;
        if (done_cnt != 1 || done_k != 6145) $display("FAIL fill_done: pulses=%0d at=%0d want 1 at 6145", done_cnt, done_k);
        else n_pass++;
    endtask

    task automatic test_collision();
        int exp_ptr = 0, done_cnt = 0, done_k = -1;
        do_reset();
        bus.clear_value = 8'h55; bus.clear_req = 1'b1;
        tick();
        bus.clear_req = 1'b0;
        for (int k = 1; k <= 6160; k++) begin
            logic        e_we;
            logic [12:0] e_addr;
            logic [7:0]  e_data;
            if (k >= 101 && k <= 103) begin
                e_we = 1'b1; e_addr = 13'(32 + k - 101); e_data = 8'(8'hA0 + k - 101);
            end else if (exp_ptr < 6144) begin
                e_we = 1'b1; e_addr = 13'(exp_ptr); e_data = 8'h55; exp_ptr++;
            end else begin
                e_we = 1'b0; e_addr = bus.wr_addr; e_data = bus.wr_data;
            end
            n_chk++;
            if (bus.wr_enable !== e_we || bus.wr_addr !== e_addr || bus.wr_data !== e_data)
                $display("FAIL coll_cycle_%0d: we=%b addr=%0d data=%h want we=%b addr=%0d data=%h",
                         k, bus.wr_enable, bus.wr_addr, bus.wr_data, e_we, e_addr, e_data);
            else n_pass++;
            if (bus.clear_done === 1'b1) begin done_cnt++; done_k = k; end
            bus.rx_strobe = (k >= 100 && k <= 102);
            bus.rx_data   = 8'(8'hA0 + k - 100);
            tick();
        end
        bus.rx_strobe = 1'b0;
        n_chk++;
        if (done_cnt != 1 || done_k != 6148) $display("FAIL coll_done: pulses=%0d at=%0d want 1 at 6148", done_cnt, done_k);
        else n_pass++;
    endtask

    task automatic test_restart();
        int bad = 0, done_cnt = 0, done_k = -1;
        do_reset();
        bus.clear_value = 8'h11; bus.clear_req = 1'b1;
        tick();
        bus.clear_req = 1'b0;
        for (int k = 1; k <= 8150; k++) begin
            if (k <= 2000) begin
                if (bus.wr_enable !== 1'b1 || bus.wr_addr !== 13'(k - 1) || bus.wr_data !== 8'h11) bad++;
            end else if (k <= 8144) begin
                if (bus.wr_enable !== 1'b1 || bus.wr_addr !== 13'(k - 2001) || bus.wr_data !== 8'h22) bad++;
            end else if (bus.wr_enable !== 1'b0) bad++;
            if (k == 2001) begin
                n_chk++;
                if (bus.wr_addr !== 13'd0 || bus.wr_data !== 8'h22)
                    $display("FAIL restart_first: addr=%0d data=%h want 0 22", bus.wr_addr, bus.wr_data);
                else n_pass++;
            end
            if (bus.clear_done === 1'b1) begin done_cnt++; done_k = k; end
            bus.clear_req   = (k == 2000);
            bus.clear_value = (k == 2000) ? 8'h22 : 8'h00;
            tick();
        end
        bus.clear_req = 1'b0;
        n_chk++;
        if (bad != 0) $display("FAIL restart_writes: bad=%0d want 0", bad);
        else n_pass++;
        n_chk++;
        if (done_cnt != 1 || done_k != 8145) $display("FAIL restart_done: pulses=%0d at=%0d want 1 at 8145", done_cnt, done_k);
        else n_pass++;
    endtask

    task automatic test_reset_midfill();
        int stray = 0;
        do_reset();
        bus.clear_value = 8'h77; bus.clear_req = 1'b1;
        tick();
        bus.clear_req = 1'b0;
        repeat (50) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_chk++;
        if (bus.busy !== 1'b0 || bus.wr_enable !== 1'b0 || bus.clear_done !== 1'b0)
            $display("FAIL midfill_reset: busy=%b we=%b done=%b want 0 0 0", bus.busy, bus.wr_enable, bus.clear_done);
        else n_pass++;
        for (int k = 0; k < 200; k++) begin
            if (bus.wr_enable !== 1'b0 || bus.clear_done !== 1'b0 || bus.busy !== 1'b0) stray++;
            tick();
        end
        n_chk++;
        if (stray != 0) $display("FAIL midfill_after: stray_cycles=%0d want 0", stray);
        else n_pass++;
    endtask

    task automatic test_echo();
        logic [7:0] bytes [2];
        bytes[0] = 8'h5A; bytes[1] = 8'hC3;
        do_reset();
        for (int i = 0; i < 2; i++) begin
            bus.rx_strobe = 1'b1; bus.rx_data = bytes[i];
            tick();
            n_chk++;
`ifdef FB_ECHO_EN
            if (bus.tx_strobe !== 1'b1 || bus.tx_data !== bytes[i])
                $display("FAIL echo_%0d: txs=%b txd=%h want 1 %h", i, bus.tx_strobe, bus.tx_data, bytes[i]);
`else
            if (bus.tx_strobe !== 1'b0 || bus.tx_data !== 8'h00)
                $display("FAIL echo_off_%0d: txs=%b txd=%h want 0 00", i, bus.tx_strobe, bus.tx_data);
`endif
            else n_pass++;
        end
        bus.rx_strobe = 1'b0;
        tick();
        n_chk++;
        if (bus.tx_strobe !== 1'b0) $display("FAIL echo_idle: txs=%b want 0", bus.tx_strobe);
        else n_pass++;
    endtask

    initial begin
        bus.rx_strobe = 1'b0; bus.frame_start = 1'b0; bus.clear_req = 1'b0;
        bus.rx_data = '0; bus.clear_value = '0;
        tick();
        test_reset();
        test_stream_map();
        test_wrap();
        test_frame_sync();
        test_fill();
        test_collision();
        test_restart();
        test_reset_midfill();
        test_echo();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
